// File: rtl/moving_avg_pkg.sv
// Shared types and sizing for the moving-average smoother and its helpers.
package moving_avg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int sum_width(input int data_w, input int max_log2_depth);
        return data_w + max_log2_depth;
    endfunction

    localparam int DATA_W_DEF         = 16;
    localparam int CHANNELS_DEF       = 3;
    localparam int MAX_LOG2_DEPTH_DEF = 4;
    localparam int SAMPLE_DIV_DEF     = 500000;

    localparam int SUM_W_DEF     = sum_width(DATA_W_DEF, MAX_LOG2_DEPTH_DEF);
    localparam int MODE_W_DEF    = $clog2(MAX_LOG2_DEPTH_DEF + 1);
    localparam int BUF_DEPTH_DEF = 1 << MAX_LOG2_DEPTH_DEF;
    localparam int PTR_W_DEF     = clog2_min1(BUF_DEPTH_DEF);
    localparam int DIV_W_DEF     = clog2_min1(SAMPLE_DIV_DEF);

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count as a one-cycle tick.
module sample_tick_gen
    import moving_avg_pkg::*;
#(
    parameter int DIV = SAMPLE_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = clog2_min1(DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel power-of-two moving average; one shared running-sum adder walks
// the channels after each sample tick.
module moving_avg_filter
    import moving_avg_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CHANNELS       = CHANNELS_DEF,
    parameter int MAX_LOG2_DEPTH = MAX_LOG2_DEPTH_DEF,
    parameter int SAMPLE_DIV     = SAMPLE_DIV_DEF
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS*DATA_W-1:0]          in,
    input  logic [$clog2(MAX_LOG2_DEPTH+1)-1:0] mode,
    input  logic                                clear,
    output logic [CHANNELS*DATA_W-1:0]          out,
    output logic                                out_valid,
    output logic                                out_full,
    output logic                                busy,
    output logic [1:0]                          fsm_state
);
    localparam int SUM_W  = sum_width(DATA_W, MAX_LOG2_DEPTH);
    localparam int MODE_W = $clog2(MAX_LOG2_DEPTH + 1);
    localparam int DEPTH  = 1 << MAX_LOG2_DEPTH;
    localparam int PTR_W  = clog2_min1(DEPTH);
    localparam int CH_W   = clog2_min1(CHANNELS);
    localparam int FILL_W = PTR_W + 1;

    state_t state_q, state_d;
    logic tick, clear_pending, go_flush, ch_last;
    logic [MODE_W-1:0] act_mode, mode_clamped;
    logic [CH_W-1:0] ch;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, flush_idx;
    logic [FILL_W-1:0] fill_cnt, fill_next, win;
    logic [CHANNELS*DATA_W-1:0] sample_q;
    logic signed [DATA_W-1:0] hist [CHANNELS][DEPTH];
    logic signed [SUM_W-1:0] sums [CHANNELS];
    logic signed [DATA_W-1:0] cur_sample, old_sample, avg;
    logic signed [SUM_W-1:0] sum_prev, sum_next;

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign mode_clamped = (mode > MODE_W'(MAX_LOG2_DEPTH)) ? MODE_W'(MAX_LOG2_DEPTH) : mode;
    assign win          = FILL_W'(1) << act_mode;
    // At the largest window the oldest sample sits exactly at wr_ptr.
    assign rd_ptr       = wr_ptr - win[PTR_W-1:0];
    assign go_flush     = clear_pending || (mode_clamped != act_mode);
    assign ch_last      = (ch == CH_W'(CHANNELS - 1));
    assign fill_next    = (fill_cnt == FILL_W'(DEPTH)) ? fill_cnt : fill_cnt + FILL_W'(1);
    assign busy         = (state_q != IDLE);
    assign fsm_state    = state_q;

    always_comb begin
        cur_sample = '0;
        old_sample = '0;
        sum_prev   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch == CH_W'(c)) begin
                cur_sample = sample_q[c*DATA_W +: DATA_W];
                old_sample = hist[c][rd_ptr];
                sum_prev   = sums[c];
            end
        end
        sum_next = sum_prev
                 + {{(SUM_W-DATA_W){cur_sample[DATA_W-1]}}, cur_sample}
                 - {{(SUM_W-DATA_W){old_sample[DATA_W-1]}}, old_sample};
        avg = DATA_W'(sum_next >>> act_mode);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = go_flush ? FLUSH : UPDATE;
            UPDATE:  if (ch_last) state_d = IDLE;
            FLUSH:   if (flush_idx == PTR_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out           <= '0;
            out_valid     <= 1'b0;
            out_full      <= 1'b0;
            clear_pending <= 1'b0;
            act_mode      <= '0;
            ch            <= '0;
            wr_ptr        <= '0;
            flush_idx     <= '0;
            fill_cnt      <= '0;
            sample_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sums[c] <= '0;
                for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (clear) clear_pending <= 1'b1;
            case (state_q)
                IDLE: if (tick) begin
                    if (go_flush) begin
                        // The sample at this tick is dropped; history restarts empty.
                        act_mode      <= mode_clamped;
                        clear_pending <= clear;
                        out           <= '0;
                        out_full      <= 1'b0;
                        fill_cnt      <= '0;
                        wr_ptr        <= '0;
                        flush_idx     <= '0;
                        for (int c = 0; c < CHANNELS; c++) sums[c] <= '0;
                    end else begin
                        sample_q <= in;
                        ch       <= '0;
                    end
                end
                UPDATE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (ch == CH_W'(c)) begin
                            sums[c]                  <= sum_next;
                            hist[c][wr_ptr]          <= cur_sample;
                            out[c*DATA_W +: DATA_W]  <= avg;
                        end
                    end
                    if (ch_last) begin
                        wr_ptr    <= wr_ptr + PTR_W'(1);
                        fill_cnt  <= fill_next;
                        out_full  <= (fill_next >= win);
                        out_valid <= 1'b1;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                FLUSH: begin
                    for (int c = 0; c < CHANNELS; c++) hist[c][flush_idx] <= '0;
                    flush_idx <= flush_idx + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter: reset timing, a table of sample vectors
// across window modes, flush behaviour and reset during an update.
module tb_moving_avg_filter;
    localparam int DATA_W         = 16;
    localparam int CHANNELS       = 3;
    localparam int MAX_LOG2_DEPTH = 4;
    localparam int SAMPLE_DIV     = 20;
    localparam int OUT_W          = CHANNELS * DATA_W;

    typedef struct {
        logic [2:0]  mode;
        bit          clr;
        bit          flush;
        logic [15:0] in0, in1, in2;
        logic [15:0] e0, e1, e2;
        bit          full;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [OUT_W-1:0] in_bus;
    logic [2:0]       mode;
    logic             clear;
    logic [OUT_W-1:0] out;
    logic             out_valid, out_full, busy;
    logic [1:0]       fsm_state;

    int n_checks;
    int n_fail;
    vec_t vecs[$];
    logic [OUT_W:0] exp_q[$];

    moving_avg_filter #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS),
        .MAX_LOG2_DEPTH(MAX_LOG2_DEPTH), .SAMPLE_DIV(SAMPLE_DIV)
    ) dut (
        .clk(clk), .reset(reset), .in(in_bus), .mode(mode), .clear(clear),
        .out(out), .out_valid(out_valid), .out_full(out_full), .busy(busy),
        .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advances one cycle at a time, sampling at the falling edge, until out_valid.
    task automatic wait_valid(input int max_cyc, output int n, output int busy_at, output bit ok);
        n = 0;
        busy_at = -1;
        ok = 1'b0;
        while (n < max_cyc && !ok) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (busy && busy_at < 0) busy_at = n;
            if (out_valid) ok = 1'b1;
        end
    endtask

    task automatic flush_check(input string tag);
        int n, len;
        bit seen_valid;
        n = 0;
        seen_valid = 1'b0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
            if (out_valid) seen_valid = 1'b1;
        end
        check({tag, "_flush_start"}, busy, 1);
        check({tag, "_flush_state"}, fsm_state, 2);
        len = 0;
        while (busy && len < 40) begin
            if (out_valid) seen_valid = 1'b1;
            len++;
            @(negedge clk);
        end
        check({tag, "_flush_len"}, len, 16);
        check({tag, "_flush_no_valid"}, seen_valid, 0);
    endtask

    task automatic reset_scenario(input string tag);
        int n, busy_at;
        bit ok;
        reset  = 1'b0;
        in_bus = '0;
        mode   = '0;
        clear  = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_rst_out"}, out, 0);
        check({tag, "_rst_valid"}, out_valid, 0);
        check({tag, "_rst_full"}, out_full, 0);
        check({tag, "_rst_busy"}, busy, 0);
        reset = 1'b1;
        wait_valid(40, n, busy_at, ok);
        check({tag, "_first_valid_edges"}, n, 23);
        check({tag, "_first_busy_edge"}, busy_at, 20);
        check({tag, "_first_out"}, out, 0);
        check({tag, "_first_full"}, out_full, 1);
    endtask

    task automatic add_row(input logic [2:0] m, input bit clr, input bit fl,
                           input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2,
                           input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                           input bit f);
        vec_t v;
        v.mode = m; v.clr = clr; v.flush = fl;
        v.in0 = i0; v.in1 = i1; v.in2 = i2;
        v.e0 = x0; v.e1 = x1; v.e2 = x2;
        v.full = f;
        vecs.push_back(v);
    endtask

    initial begin
        int n, busy_at, ramp;
        bit ok;
        logic [OUT_W:0] exp_w;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        in_bus   = '0;
        mode     = '0;
        clear    = 1'b0;

        reset_scenario("por");

        // Pass-through (mode 0): every output equals its input, sign intact.
        add_row(0, 0, 0, 16'h1234, 16'h8000, 16'h0005, 16'h1234, 16'h8000, 16'h0005, 1);
        add_row(0, 0, 0, 16'h7fff, 16'hffff, 16'h0001, 16'h7fff, 16'hffff, 16'h0001, 1);
        add_row(0, 0, 0, 16'h0000, 16'h0102, 16'hfff0, 16'h0000, 16'h0102, 16'hfff0, 1);
        // Clear + window 4, zeros averaged in while filling.
        add_row(2, 1, 1, 16'd8, 16'd100, 16'hfff8, 16'd2, 16'd25,  16'hfffe, 0);
        add_row(2, 0, 0, 16'd8, 16'd100, 16'hfff8, 16'd4, 16'd50,  16'hfffc, 0);
        add_row(2, 0, 0, 16'd8, 16'd100, 16'hfff8, 16'd6, 16'd75,  16'hfffa, 0);
        add_row(2, 0, 0, 16'd8, 16'd100, 16'hfff8, 16'd8, 16'd100, 16'hfff8, 1);
        add_row(2, 0, 0, 16'd8, 16'd100, 16'hfff8, 16'd8, 16'd100, 16'hfff8, 1);
        // Window 2, floor rounding of negatives: -3>>>1 = -2, -7>>>1 = -4.
        add_row(1, 1, 1, 16'd5, 16'd1, 16'hfffd, 16'd2, 16'd0, 16'hfffe, 0);
        add_row(1, 0, 0, 16'd6, 16'd0, 16'hfffc, 16'd5, 16'd0, 16'hfffc, 1);
        // Mode change alone forces a flush.
        add_row(2, 0, 1, 16'd40, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 0);
        add_row(2, 0, 0, 16'd40, 16'd0, 16'd0, 16'd20, 16'd0, 16'd0, 0);
        // Window 16 ramp of 1000: n*1000/16 floored, full only at the 16th.
        for (int k = 1; k <= 16; k++) begin
            ramp = (k * 1000) / 16;
            add_row(4, 0, (k == 1), 16'd1000, 16'd1000, 16'd1000,
                    16'(ramp), 16'(ramp), 16'(ramp), (k == 16));
        end

        foreach (vecs[i]) begin
            in_bus = {vecs[i].in2, vecs[i].in1, vecs[i].in0};
            mode   = vecs[i].mode;
            if (vecs[i].clr) begin
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
            if (vecs[i].flush) flush_check($sformatf("row%0d", i));
            exp_q.push_back({vecs[i].full, vecs[i].e2, vecs[i].e1, vecs[i].e0});
            wait_valid(40, n, busy_at, ok);
            check($sformatf("row%0d_valid_seen", i), ok, 1);
            exp_w = exp_q.pop_front();
            if (ok) begin
                check($sformatf("row%0d_out", i), out, exp_w[OUT_W-1:0]);
                check($sformatf("row%0d_full", i), out_full, exp_w[OUT_W]);
                check($sformatf("row%0d_busy_low", i), busy, 0);
            end
        end

        // Reset asserted right after the second channel update edge.
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("midrst_busy_before", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_out", out, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_full", out_full, 0);
        check("midrst_state", fsm_state, 0);
        @(negedge clk);
        reset_scenario("after_midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
